// File: rtl/pixel_pkg.sv
// Shared definitions for the pixel stream reader: frame geometry defaults,
// bytes per pixel and the reader state encoding.
package pixel_pkg;

   localparam int DEF_WIDTH  = 512;
   localparam int DEF_HEIGHT = 512;
   localparam int PIX_BYTES  = 3;
   localparam int FRAME_PIX  = DEF_WIDTH * DEF_HEIGHT;

   typedef enum logic [2:0] {
      IDLE,
      RD0,
      RD1,
      RD2,
      RD3,
      OUT,
      DONE
   } reader_state_t;

   function automatic int frame_pixels(input int w, input int h);
      return w * h;
   endfunction

endpackage

// File: rtl/pixel_stream_reader_if.sv
// Frame-memory read port plus RGB pixel valid/ready stream of the reader.
// Optional pix_eol is present when PIXEL_READER_EOL_EN is defined.
interface pixel_stream_reader_if #(
   parameter int ADDR_W = 20
);

   logic              mem_rd;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_rdata;
   logic              pix_valid;
   logic              pix_ready;
   logic [7:0]        R;
   logic [7:0]        G;
   logic [7:0]        B;
   logic              pix_last;
`ifdef PIXEL_READER_EOL_EN
   logic              pix_eol;
`endif

   modport master (
      output mem_rd,
      output mem_addr,
      input  mem_rdata,
      output pix_valid,
      input  pix_ready,
      output R,
      output G,
      output B,
      output pix_last
`ifdef PIXEL_READER_EOL_EN
      , output pix_eol
`endif
   );

   modport slave (
      input  mem_rd,
      input  mem_addr,
      output mem_rdata,
      input  pix_valid,
      output pix_ready,
      input  R,
      input  G,
      input  B,
      input  pix_last
`ifdef PIXEL_READER_EOL_EN
      , input pix_eol
`endif
   );

endinterface

// File: rtl/pixel_pos_counter.sv
// Pixel index (and optional column) tracker for the reader; the column
// counter exists only when PIXEL_READER_EOL_EN is defined.
module pixel_pos_counter
   import pixel_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int HEIGHT = DEF_HEIGHT,
   parameter int CNT_W  = 18
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             incr,
   output logic [CNT_W-1:0] idx,
   output logic             last
`ifdef PIXEL_READER_EOL_EN
   , output logic           eol
`endif
);

   localparam int FRAME = frame_pixels(WIDTH, HEIGHT);

   assign last = (idx == CNT_W'(FRAME - 1));

   // idx parks on the final pixel so it never leaves the frame.
   always_ff @(posedge clk) begin
      if (!rst) begin
         idx <= '0;
      end else if (clear) begin
         idx <= '0;
      end else if (incr && !last) begin
         idx <= idx + CNT_W'(1);
      end
   end

`ifdef PIXEL_READER_EOL_EN
   localparam int COL_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   logic [COL_W-1:0] col;

   assign eol = (col == COL_W'(WIDTH - 1));

   always_ff @(posedge clk) begin
      if (!rst) begin
         col <= '0;
      end else if (clear) begin
         col <= '0;
      end else if (incr) begin
         col <= eol ? '0 : col + COL_W'(1);
      end
   end
`endif

endmodule

// File: rtl/pixel_stream_reader.sv
// Streams one RGB frame from a byte-wide synchronous-read memory onto a
// valid/ready pixel interface. PIXEL_READER_EOL_EN adds the pix_eol flag.
module pixel_stream_reader
   import pixel_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int HEIGHT = DEF_HEIGHT,
   parameter int ADDR_W = 20,
   parameter int CNT_W  = 18
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   output logic                  busy,
   output logic                  frame_done,
   output logic [CNT_W-1:0]      pix_count,
   pixel_stream_reader_if.master bus
);

   localparam int FRAME   = frame_pixels(WIDTH, HEIGHT);
   // A full frame of FRAME == 2**CNT_W pixels cannot be represented; the count clamps to all-ones.
   localparam int CNT_CAP = (FRAME > (2 ** CNT_W) - 1) ? (2 ** CNT_W) - 1 : FRAME;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CNT_CAP);

   reader_state_t     state, state_nx;
   logic [ADDR_W-1:0] ptr, ptr_nx;
   logic [7:0]        r_sh, r_sh_nx, g_sh, g_sh_nx;
   logic [7:0]        r_q, r_nx, g_q, g_nx, b_q, b_nx;
   logic              last_q, last_nx;
   logic              valid_q, valid_nx;
   logic              rd_q, rd_nx;
   logic [ADDR_W-1:0] addr_q, addr_nx;
   logic              busy_q, busy_nx;
   logic              done_q, done_nx;
   logic [CNT_W-1:0]  count_q, count_nx;
   logic              pos_clear, pos_incr, pos_last;
   logic [CNT_W-1:0]  pos_idx;
   logic              handshake;
`ifdef PIXEL_READER_EOL_EN
   logic              eol_q, eol_nx, pos_eol;
`endif

   pixel_pos_counter #(
      .WIDTH (WIDTH),
      .HEIGHT(HEIGHT),
      .CNT_W (CNT_W)
   ) u_pos (
      .clk  (clk),
      .rst  (rst),
      .clear(pos_clear),
      .incr (pos_incr),
      .idx  (pos_idx),
      .last (pos_last)
`ifdef PIXEL_READER_EOL_EN
      , .eol(pos_eol)
`endif
   );

   assign handshake = valid_q & bus.pix_ready;

   // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
   always_comb begin
      state_nx  = state;
      ptr_nx    = ptr;
      r_sh_nx   = r_sh;
      g_sh_nx   = g_sh;
      r_nx      = r_q;
      g_nx      = g_q;
      b_nx      = b_q;
      last_nx   = last_q;
      count_nx  = count_q;
      pos_clear = 1'b0;
      pos_incr  = 1'b0;
`ifdef PIXEL_READER_EOL_EN
      eol_nx    = eol_q;
`endif

      case (state)
         IDLE: begin
            if (start) begin
               ptr_nx    = '0;
               count_nx  = '0;
               pos_clear = 1'b1;
               state_nx  = RD0;
            end
         end
         RD0: state_nx = RD1;
         RD1: begin
            r_sh_nx  = bus.mem_rdata;
            state_nx = RD2;
         end
         RD2: begin
            g_sh_nx  = bus.mem_rdata;
            state_nx = RD3;
         end
         RD3: begin
            r_nx     = r_sh;
            g_nx     = g_sh;
            b_nx     = bus.mem_rdata;
            last_nx  = pos_last;
`ifdef PIXEL_READER_EOL_EN
            eol_nx   = pos_eol;
`endif
            state_nx = OUT;
         end
         OUT: begin
            if (handshake) begin
               pos_incr = 1'b1;
               count_nx = (count_q == CNT_MAX) ? count_q : count_q + CNT_W'(1);
               last_nx  = 1'b0;
`ifdef PIXEL_READER_EOL_EN
               eol_nx   = 1'b0;
`endif
               // The pointer stays on the final pixel so it never passes the frame end.
               if (last_q) begin
                  state_nx = DONE;
               end else begin
                  ptr_nx   = ptr + ADDR_W'(PIX_BYTES);
                  state_nx = RD0;
               end
            end
         end
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase

      // Registered outputs are derived from the state being entered.
      rd_nx    = (state_nx == RD0) || (state_nx == RD1) || (state_nx == RD2);
      valid_nx = (state_nx == OUT);
      busy_nx  = (state_nx != IDLE);
      done_nx  = (state_nx == DONE);
      case (state_nx)
         RD0:     addr_nx = ptr_nx;
         RD1:     addr_nx = ptr_nx + ADDR_W'(1);
         RD2:     addr_nx = ptr_nx + ADDR_W'(2);
         default: addr_nx = addr_q;
      endcase
   end

   // NOTE: reset is synchronous here: rst is only looked at inside the clocked block.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state   <= IDLE;
         ptr     <= '0;
         r_sh    <= '0;
         g_sh    <= '0;
         r_q     <= '0;
         g_q     <= '0;
         b_q     <= '0;
         last_q  <= 1'b0;
         valid_q <= 1'b0;
         rd_q    <= 1'b0;
         addr_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         count_q <= '0;
`ifdef PIXEL_READER_EOL_EN
         eol_q   <= 1'b0;
`endif
      end else begin
         // NOTE: non-blocking so every register samples the pre-edge values.
         state   <= state_nx;
         ptr     <= ptr_nx;
         r_sh    <= r_sh_nx;
         g_sh    <= g_sh_nx;
         r_q     <= r_nx;
         g_q     <= g_nx;
         b_q     <= b_nx;
         last_q  <= last_nx;
         valid_q <= valid_nx;
         rd_q    <= rd_nx;
         addr_q  <= addr_nx;
         busy_q  <= busy_nx;
         done_q  <= done_nx;
         count_q <= count_nx;
`ifdef PIXEL_READER_EOL_EN
         eol_q   <= eol_nx;
`endif
      end
   end

   assign busy          = busy_q;
   assign frame_done    = done_q;
   assign pix_count     = count_q;
   assign bus.mem_rd    = rd_q;
   assign bus.mem_addr  = addr_q;
   assign bus.pix_valid = valid_q;
   assign bus.R         = r_q;
   assign bus.G         = g_q;
   assign bus.B         = b_q;
   assign bus.pix_last  = last_q;
`ifdef PIXEL_READER_EOL_EN
   assign bus.pix_eol   = eol_q;
`endif

endmodule

// File: tb/tb_pixel_stream_reader.sv
// Self-checking bench for pixel_stream_reader on a 4x2 frame with a
// behavioural frame memory, random data and random downstream back-pressure.
module tb_pixel_stream_reader;

   localparam int W      = 4;
   localparam int H      = 2;
   localparam int FRAME  = W * H;
   localparam int BYTES  = FRAME * 3;
   localparam int ADDR_W = 20;
   localparam int CNT_W  = 18;

   logic             clk = 1'b0;
   logic             rst;
   logic             start;
   logic             busy;
   logic             frame_done;
   logic [CNT_W-1:0] pix_count;

   pixel_stream_reader_if #(.ADDR_W(ADDR_W)) bus ();

   pixel_stream_reader #(
      .WIDTH (W),
      .HEIGHT(H),
      .ADDR_W(ADDR_W),
      .CNT_W (CNT_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .busy      (busy),
      .frame_done(frame_done),
      .pix_count (pix_count),
      .bus       (bus)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Frame memory model: one-cycle synchronous read, garbage when not read.
   logic [7:0] mem [0:BYTES-1];

   always @(posedge clk) begin
      if (bus.mem_rd && int'(bus.mem_addr) < BYTES)
         bus.mem_rdata <= mem[int'(bus.mem_addr)];
      else
         bus.mem_rdata <= 8'($urandom);
   end

   // Reference: pixel k is bytes 3k..3k+2; last on k==FRAME-1; eol on k%W==W-1.
   int mon_idx   = 0;
   int done_cnt  = 0;
   logic prev_done = 1'b0;

   function automatic logic [23:0] exp_pix(input int k);
      if (k < 0 || k >= FRAME) return 24'hxxxxxx;
      return {mem[3*k], mem[3*k+1], mem[3*k+2]};
   endfunction

   always @(negedge clk) begin
      if (!rst) begin
         mon_idx   = 0;
         prev_done = 1'b0;
      end else begin
         if (!busy) mon_idx = 0;
         if (busy) check("pix_count", 32'(pix_count), 32'(mon_idx));
         if (bus.mem_rd) check("rd_addr_pixel", 32'(int'(bus.mem_addr) / 3), 32'(mon_idx));
         if (bus.pix_valid) begin
            check("pix_rgb", {8'h0, bus.R, bus.G, bus.B}, {8'h0, exp_pix(mon_idx)});
            check("pix_last", 32'(bus.pix_last), 32'(mon_idx == FRAME - 1));
`ifdef PIXEL_READER_EOL_EN
            check("pix_eol", 32'(bus.pix_eol), 32'((mon_idx % W) == W - 1));
`endif
            check("rd_while_valid", 32'(bus.mem_rd), 32'd0);
            if (bus.pix_ready) mon_idx++;
         end
         if (frame_done) begin
            check("done_single_cycle", 32'(prev_done), 32'd0);
            check("done_pixel_total", 32'(mon_idx), 32'(FRAME));
            done_cnt++;
         end
         prev_done = frame_done;
      end
   end

   // Downstream ready: always-on, random, plus a targeted stall of one pixel.
   bit rand_ready = 1'b0;
   int stall_pix  = -1;
   int stall_left = 0;

   initial begin
      bus.pix_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (stall_left > 0 && bus.pix_valid && mon_idx == stall_pix) begin
            bus.pix_ready = 1'b0;
            stall_left--;
         end else if (rand_ready) begin
            bus.pix_ready = ($urandom_range(0, 3) != 0);
         end else begin
            bus.pix_ready = 1'b1;
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick(1);
      start = 1'b0;
   endtask

   task automatic wait_done(output int cyc);
      cyc = 0;
      while (!frame_done && cyc < 600) begin
         tick(1);
         cyc++;
      end
      check("frame_done_seen", 32'(frame_done), 32'd1);
   endtask

   task automatic wait_pix(input int k);
      for (int i = 0; i < 200 && mon_idx != k; i++) tick(1);
      check("reach_pixel", 32'(mon_idx), 32'(k));
   endtask

   task automatic fill_ramp();
      for (int i = 0; i < BYTES; i++) mem[i] = 8'(i);
   endtask

   task automatic fill_random();
      for (int i = 0; i < BYTES; i++) mem[i] = 8'($urandom);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_ctrl"}, 32'({busy, bus.mem_rd, bus.pix_valid, bus.pix_last, frame_done}), 32'd0);
      check({tag, "_addr"}, 32'(bus.mem_addr), 32'd0);
      check({tag, "_rgb"}, {8'h0, bus.R, bus.G, bus.B}, 32'd0);
      check({tag, "_count"}, 32'(pix_count), 32'd0);
`ifdef PIXEL_READER_EOL_EN
      check({tag, "_eol"}, 32'(bus.pix_eol), 32'd0);
`endif
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc;
      int d0;
      int busy_seen;

      rst   = 1'b0;
      start = 1'b0;
      fill_ramp();
      tick(3);
      rst = 1'b1;
      check_all_zero("reset");

      // Ramp frame with ready held high: latency and total frame time.
      pulse_start();
      check("first_read", 32'({busy, bus.mem_rd}), 32'b11);
      check("first_addr", 32'(bus.mem_addr), 32'd0);
      tick(3);
      check("valid_not_early", 32'(bus.pix_valid), 32'd0);
      tick(1);
      check("valid_at_5", 32'(bus.pix_valid), 32'd1);
      wait_done(cyc);
      check("frame_cycles", 32'(4 + cyc), 32'd40);
      tick(1);
      check("idle_after_done", 32'({busy, frame_done}), 32'd0);
      check("count_saturated", 32'(pix_count), 32'(FRAME));
      tick(2);
      check("count_held", 32'(pix_count), 32'(FRAME));

      // Seven-cycle stall on pixel 2.
      stall_pix  = 2;
      stall_left = 7;
      pulse_start();
      tick(4);
      wait_done(cyc);
      check("stall_frame_cycles", 32'(4 + cyc), 32'd47);
      check("stall_consumed", 32'(stall_left), 32'd0);
      tick(3);

      // start during pixel 3 and during DONE are both ignored.
      d0 = done_cnt;
      pulse_start();
      wait_pix(3);
      pulse_start();
      wait_done(cyc);
      start = 1'b1;
      tick(1);
      start = 1'b0;
      busy_seen = 0;
      for (int i = 0; i < 10; i++) begin
         if (busy || frame_done) busy_seen++;
         tick(1);
      end
      check("start_in_done_ignored", 32'(busy_seen), 32'd0);
      check("one_done_per_frame", 32'(done_cnt - d0), 32'd1);

      // Reset during RD2 of pixel 4, then restart from address 0.
      pulse_start();
      tick(22);
      check("in_rd2_of_pix4", 32'({bus.mem_rd, 20'(bus.mem_addr)}), 32'({1'b1, 20'd14}));
      rst = 1'b0;
      tick(1);
      rst = 1'b1;
      check_all_zero("abort");
      tick(3);
      check("abort_quiet", 32'({busy, bus.mem_rd, bus.pix_valid}), 32'd0);
      pulse_start();
      check("restart_addr", 32'({bus.mem_rd, 20'(bus.mem_addr)}), 32'({1'b1, 20'd0}));
      wait_done(cyc);

      // Back-to-back frame: start in the first IDLE cycle after DONE.
      fill_random();
      tick(1);
      check("b2b_idle", 32'(busy), 32'd0);
      fill_random();
      start = 1'b1;
      tick(1);
      start = 1'b0;
      check("b2b_accepted", 32'(busy), 32'd1);
      check("b2b_count_cleared", 32'(pix_count), 32'd0);
      wait_done(cyc);

      // Random data and random back-pressure.
      rand_ready = 1'b1;
      for (int f = 0; f < 4; f++) begin
         tick(2);
         fill_random();
         d0 = done_cnt;
         pulse_start();
         wait_done(cyc);
         tick(1);
         check("rand_frame_done", 32'(done_cnt - d0), 32'd1);
         check("rand_count", 32'(pix_count), 32'(FRAME));
      end

      tick(3);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pixel_stream_reader.md
Name: pixel_stream_reader

Overview:
- Frame source for the approximate-multiplier image pipeline. It sits upstream of the squaring datapath and is the read-side counterpart of the pixel file writer.
- Walks a byte-wide, synchronous-read frame memory that holds interleaved R,G,B bytes.
- Assembles one RGB pixel at a time and presents it on a valid/ready handshake.
- Flags the last pixel of the frame and pulses a done strobe at frame end.

Parameters:
- WIDTH, 512, pixels per row
- HEIGHT, 512, rows per frame
- ADDR_W, 20, byte-address width; must satisfy 2^ADDR_W >= WIDTH*HEIGHT*3
- CNT_W, 18, pixel-counter width; must satisfy 2^CNT_W >= WIDTH*HEIGHT

Ports:
- clk  input  1  sole clock; all state updates on the rising edge
- rst  input  1  synchronous, active-low reset
- start  input  1  1-cycle request to stream one frame; honoured only in IDLE
- busy  output  1  high in every state except IDLE
- mem_rd  output  1  memory read strobe
- mem_addr  output  ADDR_W  byte address, valid while mem_rd=1
- mem_rdata  input  8  read data, valid exactly 1 cycle after mem_rd
- pix_valid  output  1  R,G,B hold a pixel
- pix_ready  input  1  downstream accepts the pixel
- R  output  8  red byte
- G  output  8  green byte
- B  output  8  blue byte
- pix_last  output  1  high with pix_valid for pixel WIDTH*HEIGHT-1
- frame_done  output  1  1-cycle pulse after the last pixel handshake
- pix_count  output  CNT_W  number of pixels handshaken in the current frame

Behaviour:
- Reset is sampled on clk only (rst=0 at an edge):
  - state goes to IDLE;
  - busy, mem_rd, pix_valid, pix_last, frame_done = 0;
  - mem_addr, R, G, B, pix_count = 0.
- Reset mid-frame aborts immediately:
  - no further reads are issued;
  - a mem_rdata beat returning afterwards is ignored.
- Outputs are registered. Internally a byte pointer ptr (ADDR_W) and a pixel index idx (CNT_W) are kept.
- FSM states: IDLE, RD0, RD1, RD2, RD3, OUT, DONE.
  - IDLE: on start=1, clear ptr, idx and pix_count, then go to RD0. Otherwise stay.
  - RD0: mem_rd=1, mem_addr=ptr. Go to RD1.
  - RD1: mem_rd=1, mem_addr=ptr+1. Capture mem_rdata into an internal R shadow. Go to RD2.
  - RD2: mem_rd=1, mem_addr=ptr+2. Capture G shadow. Go to RD3.
  - RD3: mem_rd=0. Capture B shadow. Load R,G,B from the shadows. Set pix_last=(idx==WIDTH*HEIGHT-1). Go to OUT.
  - OUT: pix_valid=1; R, G, B and pix_last stay stable while pix_ready=0.
    - On pix_valid & pix_ready: pix_count increments, ptr advances by 3, idx increments.
    - If pix_last is set, go to DONE; otherwise go to RD0.
  - DONE: frame_done=1 for exactly one cycle, then IDLE. busy=1 in DONE.
- Latency:
  - start seen at edge N → first read in the cycle after edge N.
  - pix_valid rises 5 cycles after edge N.
  - With pix_ready held at 1, throughput is 1 pixel per 5 cycles.
- pix_valid never depends combinationally on pix_ready. Once asserted, it stays high until the handshake.
- start while busy=1 is ignored, including in the DONE cycle. start in the first IDLE cycle after DONE is accepted.
- ptr never exceeds WIDTH*HEIGHT*3-1. No wrap-around occurs within a frame; the pointer restarts only via start.
- pix_count saturates at WIDTH*HEIGHT and holds that value through IDLE until the next start.

Optional Feature:
- Macro: PIXEL_READER_EOL_EN
- Defined:
  - adds output pix_eol (1 bit), high with pix_valid when the pixel's column index == WIDTH-1;
  - uses a column counter that resets to 0 on start and wraps to 0 after WIDTH-1 on each handshake;
  - pix_eol is 0 at reset.
- Undefined: no pix_eol port and no column counter; all other behaviour is identical.

Decomposition:
- Shared package pixel_pkg holds:
  - WIDTH and HEIGHT defaults, and PIX_BYTES=3;
  - the reader state enum (IDLE..DONE);
  - the frame-length constant FRAME_PIX=WIDTH*HEIGHT.
- One sub-module, pixel_pos_counter: holds idx and the optional column count, with clear/increment inputs and last/eol outputs.
- Memory stays external.

Test Plan:
1. WIDTH=4, HEIGHT=2, memory bytes 0x00..0x17, pix_ready=1, start pulse. Required response:
   - 8 pixels, (R,G,B)=(00,01,02) … (15,16,17);
   - pix_valid first high 5 cycles after start;
   - pix_last only on pixel 7;
   - frame_done 1 cycle later; pix_count=8.
2. Same frame, pix_ready low for 7 cycles during pixel 2. Required response:
   - R,G,B=(06,07,08) held stable and pix_valid stays 1;
   - no mem_rd while stalled;
   - the stream resumes correctly.
3. start pulsed again during pixel 3 and again during DONE. Required response: both ignored; exactly 8 pixels; second frame_done absent.
4. rst=0 while in RD2 of pixel 4. Required response:
   - next cycle: all outputs 0, mem_rd=0, busy=0;
   - a new start restarts at address 0 with pixel (00,01,02).
5. With PIXEL_READER_EOL_EN defined and WIDTH=4: pix_eol high on pixels 3 and 7 only.
6. start asserted the first IDLE cycle after frame_done. Required response: a second frame streams with pix_count restarting from 0.
